mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the datapath and bus data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, meaning the byte address width.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 valid_in  in  1  EX/MEM holds a valid instruction.
REQ-006 mem_read, mem_write  in  1 each  load or store requested.
REQ-007 funct3  in  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU.
REQ-008 addr  in  ADDR_WIDTH  byte address (the ALU result).
REQ-009 store_data  in  DATA_WIDTH  store value, right-aligned.
REQ-010 wb_control_in  in  7  {reg_write, mem_to_reg, dest[4:0]}.
REQ-011 req_valid, req_write  out  1 each; req_ready  in  1  memory request handshake.
REQ-012 req_addr  out  ADDR_WIDTH; req_wdata  out  DATA_WIDTH; req_wstrb  out  8  request payload.
REQ-013 resp_valid  in  1; resp_rdata  in  DATA_WIDTH  load response.
REQ-014 stall  out  1  hold EX/MEM and upstream stages.
REQ-015 out_valid  out  1; alu_out, mem_data_out  out  DATA_WIDTH; wb_control_out  out  7; misaligned_out  out  1  inputs to MEM/WB.

Function
REQ-016 SHALL implement the states IDLE, REQ, WAIT and DONE.
REQ-017 SHALL accept an instruction in IDLE when valid_in=1 and SHALL latch addr, funct3, store_data, alu and wb_control.
REQ-018 A non-memory or misaligned instruction SHALL stay in IDLE and SHALL drive registered outputs with out_valid=1 on the next cycle (1-cycle latency).
REQ-019 Misaligned means: H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0.
REQ-020 A misaligned instruction SHALL set misaligned_out=1, force wb_control_out[6]=0 and issue no bus request.
REQ-021 An aligned memory instruction SHALL go IDLE->REQ, and stall SHALL be asserted combinationally in that accept cycle.
REQ-022 In REQ, req_valid SHALL be 1 with a stable payload until req_ready=1.
REQ-023 req_addr SHALL be addr with bits [2:0] cleared.
REQ-024 req_wdata SHALL be store_data shifted left by 8*addr[2:0].
REQ-025 req_wstrb SHALL be the size mask (0x01/0x03/0x0F/0xFF) shifted left by addr[2:0], and SHALL be 0 for loads.
REQ-026 On the REQ handshake, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-027 In WAIT, on resp_valid=1 the block SHALL shift resp_rdata right by 8*addr[2:0], sign- or zero-extend it per funct3, register the result into mem_data_out, and go to DONE.
REQ-028 resp_valid SHALL be ignored outside WAIT; a response earlier than the cycle after the handshake is not permitted by the bus.
REQ-029 DONE SHALL last exactly one cycle with out_valid=1, then go to IDLE.
REQ-030 stall SHALL be 1 in REQ and WAIT, and 0 in DONE so that the next instruction is accepted in DONE.
REQ-031 When mem_read and mem_write are both 1, the block SHALL treat the instruction as a load.
REQ-032 out_valid SHALL be 0 on every cycle not named above.
REQ-033 alu_out, wb_control_out, mem_data_out and misaligned_out SHALL hold their values until the next out_valid.
REQ-034 For a store, mem_data_out SHALL be 0.

Reset
REQ-035 reset SHALL force state=IDLE and clear req_valid, stall, out_valid, misaligned_out, alu_out, mem_data_out and wb_control_out to 0 on the next edge.
REQ-036 Reset in REQ or WAIT SHALL abandon the access, and any later resp_valid SHALL be ignored.

Verification
REQ-037 ALU op alu=0x1234, wb_control=0x45 -> next cycle out_valid=1, alu_out=0x1234, wb_control_out=0x45, stall never asserted.
REQ-038 LB addr=0x1003, req_ready after 2 cycles, resp_rdata=0x00000000_80000000 -> req_addr=0x1000, mem_data_out=0xFFFFFFFF_FFFFFF80, stall high through WAIT.
REQ-039 SH addr=0x2006, store_data=0xABCD -> req_wstrb=0xC0, req_wdata=0xABCD_0000_0000_0000, out_valid one cycle after handshake.
REQ-040 LW addr=0x3002 -> misaligned_out=1, wb_control_out[6]=0, req_valid never asserted.
REQ-041 LWU addr=0x4004, resp_rdata=0x9000_0000_0000_0000 -> mem_data_out=0x0000_0000_9000_0000.
REQ-042 Reset asserted in WAIT, resp_valid arriving 2 cycles later -> IDLE, all outputs 0, response ignored, out_valid stays 0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Load/store unit for the MEM stage: aligns stores onto a 64-bit bus, extracts and
// extends load data, and stalls upstream stages while a bus access is in flight.
module mem_stage_lsu #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [6:0]            wb_control_in,
    output logic                  req_valid,
    output logic                  req_write,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    output logic [7:0]            req_wstrb,
    input  logic                  resp_valid,
    input  logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  stall,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [6:0]            wb_control_out,
    output logic                  misaligned_out
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [2:0]              funct3_reg;
    logic [DATA_WIDTH-1:0]   store_data_reg;
    logic [DATA_WIDTH-1:0]   alu_reg;
    logic [6:0]              wb_reg;
    logic                    is_load_reg;

    logic                    out_valid_reg;
    logic [DATA_WIDTH-1:0]   alu_out_reg;
    logic [DATA_WIDTH-1:0]   mem_data_reg;
    logic [6:0]              wb_out_reg;
    logic                    misaligned_reg;

    logic [DATA_WIDTH-1:0]   addr_as_data;
    logic                    in_is_mem;
    logic                    in_misaligned;
    logic                    accept;
    logic                    start_access;
    logic                    quick_done;
    logic [5:0]              byte_shift;
    logic [7:0]              size_mask;
    logic [DATA_WIDTH-1:0]   resp_shifted;
    logic [DATA_WIDTH-1:0]   keep_mask;
    logic                    fill_bit;
    logic [DATA_WIDTH-1:0]   load_value;

    // The ALU result arrives on the address port; fit it to the datapath width.
    generate
        if (ADDR_WIDTH >= DATA_WIDTH) begin : g_addr_trunc
            assign addr_as_data = addr[DATA_WIDTH-1:0];
        end else begin : g_addr_ext
            assign addr_as_data = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, addr};
        end
    endgenerate

    always_comb begin
        in_misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   in_misaligned = addr[0];
            2'b10:   in_misaligned = (addr[1:0] != 2'b00);
            2'b11:   in_misaligned = (addr[2:0] != 3'b000);
            default: in_misaligned = 1'b0;
        endcase
        in_misaligned = in_misaligned & in_is_mem;
    end

    assign in_is_mem    = mem_read | mem_write;
    assign accept       = !reset && valid_in && (state_reg == IDLE || state_reg == DONE);
    assign start_access = accept && in_is_mem && !in_misaligned;
    assign quick_done   = accept && !start_access;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: state_next = start_access ? REQ : IDLE;
            REQ:        if (req_ready) state_next = is_load_reg ? WAIT : DONE;
            WAIT:       if (resp_valid) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    assign stall = (state_reg == REQ) || (state_reg == WAIT) || start_access;

    // Bus payload comes only from latched state so it is stable while waiting on req_ready.
    assign byte_shift = {addr_reg[2:0], 3'b000};

    always_comb begin
        size_mask = 8'h01;
        case (funct3_reg[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign req_valid = (state_reg == REQ);
    assign req_write = (state_reg == REQ) && !is_load_reg;
    assign req_addr  = {addr_reg[ADDR_WIDTH-1:3], 3'b000};
    assign req_wdata = store_data_reg << byte_shift;
    assign req_wstrb = is_load_reg ? 8'h00 : (size_mask << addr_reg[2:0]);

    assign resp_shifted = resp_rdata >> byte_shift;

    always_comb begin
        keep_mask = '1;
        fill_bit  = 1'b0;
        case (funct3_reg[1:0])
            2'b00: begin
                keep_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
                fill_bit  = resp_shifted[7];
            end
            2'b01: begin
                keep_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
                fill_bit  = resp_shifted[15];
            end
            2'b10: begin
                keep_mask = {{(DATA_WIDTH-32){1'b0}}, 32'hFFFF_FFFF};
                fill_bit  = resp_shifted[31];
            end
            default: begin
                keep_mask = '1;
                fill_bit  = 1'b0;
            end
        endcase
        // funct3[2] selects the unsigned variants.
        fill_bit   = fill_bit & ~funct3_reg[2];
        load_value = (resp_shifted & keep_mask) | (~keep_mask & {DATA_WIDTH{fill_bit}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            funct3_reg     <= '0;
            store_data_reg <= '0;
            alu_reg        <= '0;
            wb_reg         <= '0;
            is_load_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
            alu_out_reg    <= '0;
            mem_data_reg   <= '0;
            wb_out_reg     <= '0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= quick_done || (state_next == DONE);

            if (accept) begin
                addr_reg       <= addr;
                funct3_reg     <= funct3;
                store_data_reg <= store_data;
                alu_reg        <= addr_as_data;
                wb_reg         <= wb_control_in;
                is_load_reg    <= mem_read;
            end

            if (quick_done) begin
                alu_out_reg    <= addr_as_data;
                mem_data_reg   <= '0;
                wb_out_reg     <= {wb_control_in[6] & ~in_misaligned, wb_control_in[5:0]};
                misaligned_reg <= in_misaligned;
            end

            if (state_reg == REQ && req_ready && !is_load_reg) begin
                alu_out_reg    <= alu_reg;
                mem_data_reg   <= '0;
                wb_out_reg     <= wb_reg;
                misaligned_reg <= 1'b0;
            end

            if (state_reg == WAIT && resp_valid) begin
                alu_out_reg    <= alu_reg;
                mem_data_reg   <= load_value;
                wb_out_reg     <= wb_reg;
                misaligned_reg <= 1'b0;
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign alu_out        = alu_out_reg;
    assign mem_data_out   = mem_data_reg;
    assign wb_control_out = wb_out_reg;
    assign misaligned_out = misaligned_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: expected bus requests and MEM/WB results are
// queued as stimulus is driven and compared when the DUT presents them.
module tb_mem_stage_lsu;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic [6:0]  wb_control_in;
    logic        req_valid;
    logic        req_write;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        stall;
    logic        out_valid;
    logic [63:0] alu_out;
    logic [63:0] mem_data_out;
    logic [6:0]  wb_control_out;
    logic        misaligned_out;

    mem_stage_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .wb_control_in  (wb_control_in),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wstrb      (req_wstrb),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .stall          (stall),
        .out_valid      (out_valid),
        .alu_out        (alu_out),
        .mem_data_out   (mem_data_out),
        .wb_control_out (wb_control_out),
        .misaligned_out (misaligned_out)
    );

    typedef struct {
        logic [63:0] alu;
        logic [63:0] mdata;
        logic [6:0]  wb;
        logic        mis;
    } res_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        write;
    } req_t;

    res_t res_q[$];
    req_t req_q[$];
    res_t mon_res;
    req_t mon_req;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference load extraction, byte by byte from the response word.
    function automatic logic [63:0] load_model(input logic [2:0] f3, input logic [2:0] off,
                                               input logic [63:0] rdata);
        logic [63:0] v;
        int n;
        v = '0;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(int'(off)+i) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1])
            for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    always @(negedge clk) begin
        if (req_valid && req_ready) begin
            if (req_q.size() == 0) begin
                check("req_spurious", 64'd1, 64'd0);
            end else begin
                mon_req = req_q.pop_front();
                check("req_addr", req_addr, mon_req.addr);
                check("req_wdata", req_wdata, mon_req.wdata);
                check("req_wstrb", {56'd0, req_wstrb}, {56'd0, mon_req.wstrb});
                check("req_write", {63'd0, req_write}, {63'd0, mon_req.write});
                $display("REQ  addr=%h wdata=%h wstrb=%h write=%0d", req_addr, req_wdata, req_wstrb, req_write);
            end
        end
        if (out_valid) begin
            if (res_q.size() == 0) begin
                check("out_spurious", 64'd1, 64'd0);
            end else begin
                mon_res = res_q.pop_front();
                check("alu_out", alu_out, mon_res.alu);
                check("mem_data_out", mem_data_out, mon_res.mdata);
                check("wb_control_out", {57'd0, wb_control_out}, {57'd0, mon_res.wb});
                check("misaligned_out", {63'd0, misaligned_out}, {63'd0, mon_res.mis});
                $display("OUT  alu=%h mdata=%h wb=%h mis=%0d", alu_out, mem_data_out, wb_control_out, misaligned_out);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] f3, input logic rd, input logic wr,
                         input logic [63:0] a, input logic [63:0] sd, input logic [6:0] wb,
                         input int rdy_dly, input int rsp_dly, input logic [63:0] rdata);
        logic  is_mem;
        logic  mis;
        logic  go;
        logic  [7:0] mask;
        res_t  r;
        req_t  q;
        is_mem = rd | wr;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = (a[1:0] != 2'b00);
            2'b11:   mis = (a[2:0] != 3'b000);
            default: mis = 1'b0;
        endcase
        mis = mis & is_mem;
        go = is_mem & ~mis;
        case (f3[1:0])
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            2'b10:   mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        r.alu   = a;
        r.mdata = (go && rd) ? load_model(f3, a[2:0], rdata) : 64'd0;
        r.wb    = mis ? {1'b0, wb[5:0]} : wb;
        r.mis   = mis;
        res_q.push_back(r);
        if (go) begin
            q.addr  = {a[63:3], 3'b000};
            q.wdata = sd << (8 * a[2:0]);
            q.wstrb = rd ? 8'h00 : (mask << a[2:0]);
            q.write = ~rd;
            req_q.push_back(q);
        end

        valid_in = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        addr = a; store_data = sd; wb_control_in = wb;
        #1;
        check("stall_accept", {63'd0, stall}, {63'd0, go});
        tick();
        valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        if (!go) begin
            check("quick_out_valid", {63'd0, out_valid}, 64'd1);
            check("quick_req_valid", {63'd0, req_valid}, 64'd0);
            check("quick_stall", {63'd0, stall}, 64'd0);
            return;
        end
        repeat (rdy_dly) begin
            check("req_valid_hold", {63'd0, req_valid}, 64'd1);
            check("stall_req", {63'd0, stall}, 64'd1);
            tick();
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        if (rd) begin
            repeat (rsp_dly) begin
                check("stall_wait", {63'd0, stall}, 64'd1);
                check("wait_out_valid", {63'd0, out_valid}, 64'd0);
                tick();
            end
            resp_valid = 1'b1;
            resp_rdata = rdata;
            tick();
            resp_valid = 1'b0;
            resp_rdata = {$urandom, $urandom};
        end
        check("done_out_valid", {63'd0, out_valid}, 64'd1);
        check("done_stall", {63'd0, stall}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3;
        logic [63:0] a;
        int          kind;
        checks = 0; failures = 0;
        reset = 1'b1; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        addr = '0; store_data = '0; wb_control_in = '0; req_ready = 1'b0;
        resp_valid = 1'b0; resp_rdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_req_valid", {63'd0, req_valid}, 64'd0);
        check("rst_alu_out", alu_out, 64'd0);
        check("rst_mem_data", mem_data_out, 64'd0);
        check("rst_wb", {57'd0, wb_control_out}, 64'd0);
        check("rst_mis", {63'd0, misaligned_out}, 64'd0);

        do_op(3'b000, 1'b0, 1'b0, 64'h1234, 64'd0, 7'h45, 0, 0, 64'd0);
        check("alu_op_value", alu_out, 64'h1234);
        tick();
        check("alu_op_pulse", {63'd0, out_valid}, 64'd0);

        do_op(3'b000, 1'b1, 1'b0, 64'h1003, 64'd0, 7'h61, 2, 1, 64'h0000_0000_8000_0000);
        check("lb_sign_ext", mem_data_out, 64'hFFFF_FFFF_FFFF_FF80);
        do_op(3'b001, 1'b0, 1'b1, 64'h2006, 64'hABCD, 7'h02, 0, 0, 64'd0);
        check("sh_mem_data_zero", mem_data_out, 64'd0);
        do_op(3'b010, 1'b1, 1'b0, 64'h3002, 64'd0, 7'h45, 0, 0, 64'd0);
        check("lw_mis_flag", {63'd0, misaligned_out}, 64'd1);
        check("lw_mis_wb", {57'd0, wb_control_out}, 64'h05);
        tick();
        do_op(3'b110, 1'b1, 1'b0, 64'h4004, 64'd0, 7'h4A, 1, 2, 64'h9000_0000_0000_0000);
        check("lwu_zero_ext", mem_data_out, 64'h0000_0000_9000_0000);
        do_op(3'b101, 1'b1, 1'b1, 64'h5006, 64'h1111, 7'h53, 0, 0, 64'h8001_0000_0000_0000);
        check("both_as_load", mem_data_out, 64'h0000_0000_0000_8001);
        do_op(3'b011, 1'b0, 1'b1, 64'h6000, 64'hDEAD_BEEF_0123_4567, 7'h00, 1, 0, 64'd0);

        for (int i = 0; i < 24; i++) begin
            f3   = 3'($urandom_range(0, 6));
            kind = $urandom_range(0, 3);
            a    = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            do_op(f3, kind == 1 || kind == 3, kind == 2 || kind == 3, a, {$urandom, $urandom},
                  7'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), {$urandom, $urandom});
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Abandon a load in WAIT, then deliver a stale response.
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b011;
        addr = 64'h7000; store_data = 64'd0; wb_control_in = 7'h7F;
        req_q.push_back('{addr: 64'h7000, wdata: 64'd0, wstrb: 8'h00, write: 1'b0});
        tick();
        valid_in = 1'b0; mem_read = 1'b0;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("pre_rst_wait_stall", {63'd0, stall}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wait_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("wait_rst_stall", {63'd0, stall}, 64'd0);
        check("wait_rst_req_valid", {63'd0, req_valid}, 64'd0);
        check("wait_rst_alu_out", alu_out, 64'd0);
        check("wait_rst_mem_data", mem_data_out, 64'd0);
        check("wait_rst_wb", {57'd0, wb_control_out}, 64'd0);
        check("wait_rst_mis", {63'd0, misaligned_out}, 64'd0);
        tick();
        resp_valid = 1'b1;
        resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        resp_valid = 1'b0;
        check("stale_resp_out_valid", {63'd0, out_valid}, 64'd0);
        check("stale_resp_mem_data", mem_data_out, 64'd0);
        repeat (3) tick();

        do_op(3'b100, 1'b1, 1'b0, 64'h8005, 64'd0, 7'h4C, 0, 0, 64'h0000_F700_0000_0000);
        check("lbu_after_rst", mem_data_out, 64'h0000_0000_0000_00F7);
        repeat (4) tick();
        check("res_q_empty", 64'(res_q.size()), 64'd0);
        check("req_q_empty", 64'(req_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
